ifmap_buffer_param: RTL
=======================

IFMAP_BUFFER_PARAM -- requirements
Module: ifmap_buffer_param

Interface
REQ-001 Parameter NUM_ROWS, default 35, number of ifmap rows held.
REQ-002 Parameter ROW_W, default 2048, bits per row.
REQ-003 Parameter PKT_W, default 64, bits per decompressor beat; ROW_W SHALL be an integer multiple of PKT_W, and BEATS = ROW_W/PKT_W.
REQ-004 Port clk, input, 1, single clock; all logic on posedge.
REQ-005 Port rst, input, 1, synchronous, active-high reset.
REQ-006 Port start, input, 1, begin a layer; sampled only in IDLE.
REQ-007 Port layer_type_in, input, LAYER_TYPE, CONV or FC; latched on accepted start.
REQ-008 Port stride_in, input, 2, row stride for CONV; latched on accepted start; 0 treated as 1.
REQ-009 Port pkt_valid, input, 1, decompressor beat valid.
REQ-010 Port pkt_data, input, PKT_W, decompressor beat payload.
REQ-011 Port pkt_ready, output, 1, beat accepted when pkt_valid && pkt_ready.
REQ-012 Port free_ifmap_buffer, input, 1, consumer is done with the current window.
REQ-013 Port layer_done, input, 1, with free_ifmap_buffer, ends the layer.
REQ-014 Port global_buffer_req, output, 1, rows still outstanding.
REQ-015 Port ifmap_data, output, NUM_ROWS*ROW_W, row r at bits [r*ROW_W +: ROW_W].
REQ-016 Port ifmap_data_valid, output, 1, window complete.
REQ-017 Port ifmap_data_change, output, 1, one-cycle pulse on each new valid window.

Function
REQ-018 FSM states: IDLE, FILL, READY, SHIFT.
REQ-019 IDLE + start -> FILL; target row count = NUM_ROWS for CONV, 1 for FC; write row = 0.
REQ-020 pkt_ready = 1 only in FILL/SHIFT while target rows remain; global_buffer_req equals pkt_ready.
REQ-021 Beat k (0..BEATS-1) of a row writes bits [k*PKT_W +: PKT_W] of the current write row; beat counter wraps to 0 and write row increments after beat BEATS-1.
REQ-022 On acceptance of the final beat of the final target row, next state = READY.
REQ-023 In the first READY cycle, ifmap_data_change = 1; ifmap_data_valid = 1 throughout READY and 0 in all other states.
REQ-024 READY + free_ifmap_buffer + layer_done -> IDLE; READY + free_ifmap_buffer (no done), FC -> FILL with 1 row at row 0.
REQ-025 READY + free_ifmap_buffer, CONV -> SHIFT; in that same edge rows shift down by S = stride: row r <= row r+S for r < NUM_ROWS-S; target = S rows at write row NUM_ROWS-S.
REQ-026 S >= NUM_ROWS SHALL behave as a full reload (FILL with NUM_ROWS rows).
REQ-027 free_ifmap_buffer outside READY, and start outside IDLE, SHALL be ignored.
REQ-028 Rows not being written SHALL hold value; ifmap_data is a direct register output (0-cycle read latency).

Reset
REQ-029 rst -> IDLE; all row storage 0; counters 0; pkt_ready, global_buffer_req, ifmap_data_valid, ifmap_data_change 0; latched type CONV, stride 1.
REQ-030 rst asserted mid-FILL/SHIFT SHALL abort in the same edge with no further beat accepted.

Configuration
REQ-031 Macro IFMAP_BUF_STALL_CNT_EN defined: adds output stall_cnt[15:0], counting cycles in FILL/SHIFT with pkt_valid = 0; it saturates at 16'hFFFF, is cleared on accepted start and on rst, and holds in other states.
REQ-032 Macro undefined: stall_cnt port and logic are absent; all other behaviour is identical.

Structure
REQ-033 LAYER_TYPE enum and the FSM state enum SHALL live in the shared package amadeus_pkg.
REQ-034 Beat-to-row packing (beat counter, row-write strobe) SHALL be the sub-module ifmap_row_assembler.

Verification
Bench params: NUM_ROWS=4, ROW_W=32, PKT_W=8, so BEATS=4.
REQ-035 Reset then CONV start, stride 1, 16 beats 0x00..0x0F -> after 16 accepts: valid=1, one change pulse, row0=32'h03020100, row3=32'h0F0E0D0C.
REQ-036 Then free -> SHIFT, 4 beats 0x10..0x13 -> row0=32'h07060504, row3=32'h13121110, valid=0 during shift, new change pulse.
REQ-037 Stride 3 CONV window, free -> rows 0 = old row3; 12 new beats fill rows 1..3; stride 0 behaves as stride 1.
REQ-038 FC start, 4 beats, free without done -> FILL 1 row, row0 overwritten, rows 1..3 unchanged; free+done -> IDLE, req=0.
REQ-039 pkt_valid toggled randomly, rst raised after beat 6 -> all outputs 0 next cycle; with IFMAP_BUF_STALL_CNT_EN, stall_cnt equals the count of pkt_valid-low fill cycles.

Source files
------------

// File: rtl/amadeus_pkg.sv
// -----------------------------------------------------------------------------
// amadeus_pkg
// Shared types for the ifmap buffer slice:
//   layer_type_e  - CONV / FC layer selector
//   ifmap_state_e - ifmap buffer FSM states
//   eff_stride()  - maps the raw 2-bit stride to the stride actually used
// -----------------------------------------------------------------------------
package amadeus_pkg;

  typedef enum logic [0:0] {
    LAYER_CONV = 1'b0,
    LAYER_FC   = 1'b1
  } layer_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2,
    ST_SHIFT = 2'd3
  } ifmap_state_e;

  // A programmed stride of 0 is treated as 1.
  function automatic logic [1:0] eff_stride(input logic [1:0] raw);
    logic [1:0] res;
    if (raw == 2'd0) begin
      res = 2'd1;
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/ifmap_row_assembler.sv
// -----------------------------------------------------------------------------
// ifmap_row_assembler
// Tracks which beat of the current row the next accepted decompressor beat
// lands in.
//   clk, rst   - clock, synchronous active-high reset
//   beat_fire  - a beat is accepted this cycle
//   beat_wr    - write strobe for the selected beat slice
//   beat_idx   - beat slot (0..BEATS-1) the accepted beat goes to
//   row_done   - the accepted beat completes the current row
// -----------------------------------------------------------------------------
module ifmap_row_assembler
  import amadeus_pkg::*;
#(
  parameter int BEATS  = 32,
  parameter int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_fire,
  output logic              beat_wr,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              row_done
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [BEAT_W-1:0] beat_cnt_r;
  logic              last_beat_s;

  assign last_beat_s = (beat_cnt_r == LAST_BEAT);

  // Beat counter: wraps to 0 after the last beat of a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r <= {BEAT_W{1'b0}};
    end else if (beat_fire) begin
      if (last_beat_s) begin
        beat_cnt_r <= {BEAT_W{1'b0}};
      end else begin
        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
      end
    end
  end

  assign beat_wr  = beat_fire;
  assign beat_idx = beat_cnt_r;
  assign row_done = beat_fire & last_beat_s;

endmodule

// File: rtl/ifmap_buffer_param.sv
// -----------------------------------------------------------------------------
// ifmap_buffer_param
// Holds NUM_ROWS ifmap rows assembled from decompressor beats and presents them
// as one window. CONV layers slide the window down by the stride; FC layers
// reload row 0 only.
//   clk, rst              - clock, synchronous active-high reset
//   start                 - begin a layer (IDLE only)
//   layer_type_in         - CONV / FC, latched on accepted start
//   stride_in             - CONV row stride (0 means 1), latched on start
//   pkt_valid/pkt_data    - decompressor beat
//   pkt_ready             - beat accepted when pkt_valid && pkt_ready
//   free_ifmap_buffer     - consumer done with current window (READY only)
//   layer_done            - with free_ifmap_buffer, ends the layer
//   global_buffer_req     - rows still outstanding (same as pkt_ready)
//   ifmap_data            - row r at [r*ROW_W +: ROW_W]
//   ifmap_data_valid      - window complete
//   ifmap_data_change     - one-cycle pulse on each new valid window
// Optional macro IFMAP_BUF_STALL_CNT_EN adds stall_cnt[15:0]: cycles spent
// waiting for beats (FILL/SHIFT with pkt_valid low), saturating.
// -----------------------------------------------------------------------------
module ifmap_buffer_param
  import amadeus_pkg::*;
#(
  parameter int NUM_ROWS = 35,
  parameter int ROW_W    = 2048,
  parameter int PKT_W    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  layer_type_e               layer_type_in,
  input  logic [1:0]                stride_in,
  input  logic                      pkt_valid,
  input  logic [PKT_W-1:0]          pkt_data,
  output logic                      pkt_ready,
  input  logic                      free_ifmap_buffer,
  input  logic                      layer_done,
  output logic                      global_buffer_req,
  output logic [NUM_ROWS*ROW_W-1:0] ifmap_data,
  output logic                      ifmap_data_valid,
  output logic                      ifmap_data_change
`ifdef IFMAP_BUF_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int BEATS     = ROW_W / PKT_W;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CNT_W     = $clog2(NUM_ROWS + 1);

  ifmap_state_e         state_r, state_nxt_s;
  layer_type_e          layer_r;
  logic [1:0]           stride_r;
  logic [CNT_W-1:0]     rows_left_r, rows_left_nxt_s;
  logic [ROW_IDX_W-1:0] write_row_r, write_row_nxt_s;
  logic                 load_cfg_s;
  logic                 shift_en_s;
  logic                 pkt_ready_r;
  logic                 valid_r;
  logic                 change_r;
  logic                 pkt_fire_s;
  logic                 beat_wr_s;
  logic [BEAT_W-1:0]    beat_idx_s;
  logic                 row_done_s;
  logic [ROW_W-1:0]     rows_r [NUM_ROWS];

  // Gated by rst so no beat appears accepted on the reset edge.
  assign pkt_ready         = pkt_ready_r & ~rst;
  assign global_buffer_req = pkt_ready;
  assign pkt_fire_s        = pkt_valid & pkt_ready;
  assign ifmap_data_valid  = valid_r;
  assign ifmap_data_change = change_r;

  ifmap_row_assembler #(
    .BEATS  (BEATS),
    .BEAT_W (BEAT_W)
  ) u_row_asm (
    .clk       (clk),
    .rst       (rst),
    .beat_fire (pkt_fire_s),
    .beat_wr   (beat_wr_s),
    .beat_idx  (beat_idx_s),
    .row_done  (row_done_s)
  );

  // Next-state, target-row and write-row decisions.
  always_comb begin
    state_nxt_s     = state_r;
    rows_left_nxt_s = rows_left_r;
    write_row_nxt_s = write_row_r;
    load_cfg_s      = 1'b0;
    shift_en_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s     = ST_FILL;
          load_cfg_s      = 1'b1;
          write_row_nxt_s = {ROW_IDX_W{1'b0}};
          if (layer_type_in == LAYER_FC) begin
            rows_left_nxt_s = CNT_W'(1);
          end else begin
            rows_left_nxt_s = CNT_W'(NUM_ROWS);
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILL, ST_SHIFT: begin
        if (row_done_s) begin
          write_row_nxt_s = write_row_r + ROW_IDX_W'(1);
          rows_left_nxt_s = rows_left_r - CNT_W'(1);
          if (rows_left_r == CNT_W'(1)) begin
            state_nxt_s = ST_READY;
          end else begin
            state_nxt_s = state_r;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_READY: begin
        if (!free_ifmap_buffer) begin
          state_nxt_s = ST_READY;
        end else if (layer_done) begin
          state_nxt_s = ST_IDLE;
        end else if (layer_r == LAYER_FC) begin
          state_nxt_s     = ST_FILL;
          rows_left_nxt_s = CNT_W'(1);
          write_row_nxt_s = {ROW_IDX_W{1'b0}};
        end else if (32'(stride_r) >= 32'(NUM_ROWS)) begin
          // Stride spans the whole window: nothing to keep, reload all rows.
          state_nxt_s     = ST_FILL;
          rows_left_nxt_s = CNT_W'(NUM_ROWS);
          write_row_nxt_s = {ROW_IDX_W{1'b0}};
        end else begin
          state_nxt_s     = ST_SHIFT;
          shift_en_s      = 1'b1;
          rows_left_nxt_s = CNT_W'(stride_r);
          write_row_nxt_s = ROW_IDX_W'(NUM_ROWS - 32'(stride_r));
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, latched layer config and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      layer_r     <= LAYER_CONV;
      stride_r    <= 2'd1;
      rows_left_r <= {CNT_W{1'b0}};
      write_row_r <= {ROW_IDX_W{1'b0}};
      pkt_ready_r <= 1'b0;
      valid_r     <= 1'b0;
      change_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rows_left_r <= rows_left_nxt_s;
      write_row_r <= write_row_nxt_s;
      if (load_cfg_s) begin
        layer_r  <= layer_type_in;
        stride_r <= eff_stride(stride_in);
      end
      pkt_ready_r <= (state_nxt_s == ST_FILL) || (state_nxt_s == ST_SHIFT);
      valid_r     <= (state_nxt_s == ST_READY);
      change_r    <= (state_nxt_s == ST_READY) && (state_r != ST_READY);
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    // Source rows for a shift by 1/2/3; rows with no source in range hold.
    localparam int SRC1 = (r + 1 < NUM_ROWS) ? r + 1 : r;
    localparam int SRC2 = (r + 2 < NUM_ROWS) ? r + 2 : r;
    localparam int SRC3 = (r + 3 < NUM_ROWS) ? r + 3 : r;

    logic [ROW_W-1:0] shift_src_s;

    // Select the row that slides into this slot for the latched stride.
    always_comb begin
      case (stride_r)
        2'd2:    shift_src_s = rows_r[SRC2];
        2'd3:    shift_src_s = rows_r[SRC3];
        default: shift_src_s = rows_r[SRC1];
      endcase
    end

    // Row storage: window shift, or beat write into the selected slice.
    always_ff @(posedge clk) begin
      if (rst) begin
        rows_r[r] <= {ROW_W{1'b0}};
      end else if (shift_en_s) begin
        rows_r[r] <= shift_src_s;
      end else if (beat_wr_s && (write_row_r == ROW_IDX_W'(r))) begin
        for (int k = 0; k < BEATS; k++) begin
          if (beat_idx_s == BEAT_W'(k)) begin
            rows_r[r][k*PKT_W +: PKT_W] <= pkt_data;
          end
        end
      end
    end

    assign ifmap_data[r*ROW_W +: ROW_W] = rows_r[r];
  end

`ifdef IFMAP_BUF_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles waiting on the decompressor.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == ST_IDLE) && start) begin
      stall_cnt_r <= 16'h0000;
    end else if (((state_r == ST_FILL) || (state_r == ST_SHIFT)) && !pkt_valid &&
                 (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule
